axi_rdata_packer: RTL and testbench
===================================

// Module: axi_rdata_packer
// PURPOSE
//  AXI read-data transmitter for the DDR controller. Takes one read burst command at a time and
//  the per-clock byte stream from the DRAM read-capture path, then packs the bytes into RDATA beats.
//  Beats are buffered in a small FIFO and driven on the AXI R channel (RID/RDATA/RRESP/RLAST/RVALID)
//  to the AXI master.
//  Sits between the DRAM read datapath and the top-level AXI slave port.
// PARAMETERS
//  DATA_W      64  RDATA width in bits (bytes per beat max = DATA_W/8 = 8)
//  ID_W        2   transaction ID width
//  FIFO_DEPTH  4   beat FIFO entries, power of two, >=2
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  n_rst        in   1       asynchronous active-low reset
//  cmd_valid    in   1       burst command valid
//  cmd_ready    out  1       packer idle, can accept command
//  cmd_id       in   ID_W    ARID of burst
//  cmd_len      in   8       ARLEN (beats-1)
//  cmd_size     in   3       ARSIZE (bytes per beat = 1<<size)
//  byte_valid   in   1       byte_data valid this cycle
//  byte_ready   out  1       packer will accept a byte this cycle
//  byte_data    in   8       captured DRAM byte, lowest address first
//  RID          out  ID_W    AXI read ID
//  RDATA        out  DATA_W  AXI read data
//  RRESP        out  2       AXI read response
//  RLAST        out  1       last beat of burst
//  RVALID       out  1       R beat valid
//  RREADY       in   1       master accepts beat
//  overrun      out  1       sticky: byte offered while byte_ready=0
// BEHAVIOUR
//  Reset values: cmd_ready=1, byte_ready=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, overrun=0,
//   FIFO empty, FSM=IDLE. Reset mid-burst discards the assembly register and all FIFO entries.
//  FSM IDLE -> COLLECT on cmd_valid&&cmd_ready; cmd_ready=1 only in IDLE.
//   The command is latched at that edge:
//   - id; beats_left=cmd_len+1; bpb=1<<min(cmd_size,3)
//   - resp=SLVERR(2'b10) if cmd_size>3, else OKAY(2'b00)
//  COLLECT: byte_ready = !pend && (fifo_count < FIFO_DEPTH).
//   Each byte_valid&&byte_ready writes byte into lane byte_cnt of the assembly register.
//   byte_cnt increments.
//   Lanes >= bpb are 0, so narrow beats are zero-extended and lane 0 holds the first byte.
//  Beat complete when byte accepted with byte_cnt==bpb-1: set pend=1, byte_cnt=0, and beats_left-1.
//   Next edge pushes {id,data,resp,last=(beats_left was 1)} to FIFO and clears pend.
//  After pushing last beat FSM -> IDLE in the same edge; next command is accepted the following cycle.
//  Latency: last byte of a beat accepted at edge N -> RVALID=1 after edge N+1 (FIFO was empty).
//  R channel: RVALID = FIFO non-empty; RID/RDATA/RRESP/RLAST show FIFO head.
//   Pop on RVALID&&RREADY. Outputs hold stable while RVALID&&!RREADY.
//   Push and pop in the same cycle are legal at any occupancy, including full.
//   Count is then unchanged.
//  byte_ready deasserts whenever the FIFO is full. The DRAM cannot stall:
//   - byte_valid&&!byte_ready drops the byte and sets overrun (sticky until reset)
//   - the assembly state does not change
//  byte_valid in IDLE is an overrun as well.
//  cmd_len=255 is legal (256 beats); the counter is 9 bits wide, so no wrap.
//  FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
// TESTING
//  1. Reset mid-burst:
//     - stimulus: assert n_rst=0 while 2 beats are buffered and RREADY=0
//     - check: RVALID=0 immediately (async); cmd_ready=1 after release; overrun=0
//  2. Single narrow beat:
//     - stimulus: cmd(id=1,len=0,size=0), byte A5
//     - check: one beat RDATA=64'hA5, RID=1, RLAST=1, RRESP=0, RVALID 2 edges after byte
//  3. Full-width burst:
//     - stimulus: cmd(id=2,len=31,size=3), 256 bytes 00..FF, RREADY=1
//     - check: 32 beats, beat k = bytes 8k..8k+7 little-endian, RLAST only on beat 31
//  4. Backpressure:
//     - stimulus: cmd(len=7,size=3), RREADY=0
//     - check: byte_ready drops after 4 beats (FIFO_DEPTH); RDATA of head stable
//     - then: RREADY=1 -> all 8 beats delivered in order, overrun=0
//  5. Overrun:
//     - stimulus: drive byte_valid=1 while byte_ready=0 (FIFO full)
//     - check: overrun=1 sticky; byte not present in any beat
//  6. Bad size and back-to-back:
//     - stimulus: cmd(id=3,len=1,size=5) then cmd(id=0,len=0,size=1)
//     - check: first two beats RRESP=2'b10 (8 bytes each); third RRESP=0, RID=0, RLAST=1

Source files
------------

// File: rtl/axi_rdata_packer_if.sv
// AXI R channel bundle between the read-data packer and the AXI slave port.
interface axi_rdata_packer_if #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 2
);
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport slave (
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_rdata_packer.sv
// AXI read-data packer: assembles captured DRAM bytes into R beats
// and queues them in a small FIFO ahead of the AXI R channel.
module axi_rdata_packer #(
    parameter int DATA_W     = 64,
    parameter int ID_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [7:0]        byte_data,
    output logic              overrun,
    axi_rdata_packer_if.master r
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [1:0]        resp_q, resp_d;
    logic [LW:0]       bpb_q, bpb_d;
    logic [LW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [8:0]        beats_left_q, beats_left_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              pend_q, pend_d;
    logic              overrun_q, overrun_d;
    beat_t             mem_q [FIFO_DEPTH];
    beat_t             mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              rvalid;
    logic              push;
    logic              pop;
    logic              accept;
    logic              last_lane;
    logic [2:0]        size_sat;
    beat_t             head;

    assign rvalid    = (count_q != '0);
    assign push      = pend_q;
    assign pop       = rvalid && r.RREADY;
    assign cmd_ready = (state_q == IDLE);
    assign byte_ready = (state_q == COLLECT) && !pend_q &&
                        (count_q < CW'(FIFO_DEPTH));
    assign accept    = byte_valid && byte_ready;
    assign last_lane = ({1'b0, byte_cnt_q} == (bpb_q - 1'b1));
    assign size_sat  = (cmd_size > 3'(LW)) ? 3'(LW) : cmd_size;

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        resp_d       = resp_q;
        bpb_d        = bpb_q;
        byte_cnt_d   = byte_cnt_q;
        beats_left_d = beats_left_q;
        asm_d        = asm_q;
        pend_d       = pend_q;
        overrun_d    = overrun_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d      = COLLECT;
                    id_d         = cmd_id;
                    beats_left_d = {1'b0, cmd_len} + 9'd1;
                    bpb_d        = (LW+1)'(1) << size_sat;
                    resp_d       = (cmd_size > 3'(LW)) ? SLVERR : OKAY;
                    byte_cnt_d   = '0;
                    asm_d        = '0;
                    pend_d       = 1'b0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
                    if (last_lane) begin
                        pend_d       = 1'b1;
                        byte_cnt_d   = '0;
                        beats_left_d = beats_left_q - 9'd1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
                // Completed beat leaves the assembly register one edge later
                if (pend_q) begin
                    mem_d[wr_ptr_q] = '{
                        id:   id_q,
                        data: asm_q,
                        resp: resp_q,
                        last: (beats_left_q == 9'd0)
                    };
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    pend_d   = 1'b0;
                    asm_d    = '0;
                    if (beats_left_q == 9'd0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_valid && !byte_ready) begin
            overrun_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            resp_q       <= OKAY;
            bpb_q        <= '0;
            byte_cnt_q   <= '0;
            beats_left_q <= '0;
            asm_q        <= '0;
            pend_q       <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            resp_q       <= resp_d;
            bpb_q        <= bpb_d;
            byte_cnt_q   <= byte_cnt_d;
            beats_left_q <= beats_left_d;
            asm_q        <= asm_d;
            pend_q       <= pend_d;
            overrun_q    <= overrun_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    // Empty FIFO drives zeros so stale entries never leak onto the bus
    assign head     = rvalid ? mem_q[rd_ptr_q] : '0;
    assign r.RVALID = rvalid;
    assign r.RID    = head.id;
    assign r.RDATA  = head.data;
    assign r.RRESP  = head.resp;
    assign r.RLAST  = head.last;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_axi_rdata_packer.sv
// Scoreboard bench for axi_rdata_packer: directed bursts,
// backpressure, overrun, bad size and asynchronous reset.
module tb_axi_rdata_packer;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_id;
    logic [7:0] cmd_len;
    logic [2:0] cmd_size;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       overrun;

    axi_rdata_packer_if #(.DATA_W(64), .ID_W(2)) rif ();

    axi_rdata_packer #(
        .DATA_W    (64),
        .ID_W      (2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_data (byte_data),
        .overrun   (overrun),
        .r         (rif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] pack(input logic [7:0] start, input int n);
        logic [63:0] d = '0;
        for (int i = 0; i < n; i++) begin
            d[8*i +: 8] = 8'(start + i);
        end
        return d;
    endfunction

    function automatic exp_t mk(input logic [1:0] id, input logic [63:0] d,
                                input logic [1:0] resp, input logic last);
        exp_t e;
        e.id = id;
        e.data = d;
        e.resp = resp;
        e.last = last;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic send_cmd(input logic [1:0] id, input logic [7:0] len, input logic [2:0] size);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_wait: got cmd_ready=0 want 1 within 500 cycles");
        end
        cmd_valid = 1'b1;
        cmd_id = id;
        cmd_len = len;
        cmd_size = size;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!byte_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_wait: got byte_ready=0 want 1 within 500 cycles");
        end else begin
            byte_valid = 1'b1;
            byte_data = b;
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(8'(start + i));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        if (n_rst && rif.RVALID && rif.RREADY) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_extra: got id=%0d data=%h want no beat",
                         rif.RID, rif.RDATA);
            end else begin
                mon_e = exp_q.pop_front();
                if (rif.RID !== mon_e.id || rif.RDATA !== mon_e.data ||
                    rif.RRESP !== mon_e.resp || rif.RLAST !== mon_e.last) begin
                    errors++;
                    $display("FAIL beat: got id=%0d data=%h resp=%0d last=%0d want id=%0d data=%h resp=%0d last=%0d",
                             rif.RID, rif.RDATA, rif.RRESP, rif.RLAST,
                             mon_e.id, mon_e.data, mon_e.resp, mon_e.last);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_id = '0;
        cmd_len = '0;
        cmd_size = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        rif.RREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_rvalid", 64'(rif.RVALID), 64'd0);
        chk("rst_rlast", 64'(rif.RLAST), 64'd0);
        chk("rst_rid", 64'(rif.RID), 64'd0);
        chk("rst_rdata", rif.RDATA, 64'd0);
        chk("rst_rresp", 64'(rif.RRESP), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);

        // single narrow beat and its latency
        send_cmd(2'd1, 8'd0, 3'd0);
        exp_q.push_back(mk(2'd1, 64'hA5, 2'b00, 1'b1));
        send_byte(8'hA5);
        chk("lat_edge1_rvalid", 64'(rif.RVALID), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_rvalid", 64'(rif.RVALID), 64'd1);
        rif.RREADY = 1'b1;
        drain();

        // full-width 32-beat burst
        send_cmd(2'd2, 8'd31, 3'd3);
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back(mk(2'd2, pack(8'(8*k), 8), 2'b00, k == 31));
        end
        send_seq(8'h00, 256);
        drain();

        // backpressure
        rif.RREADY = 1'b0;
        send_cmd(2'd1, 8'd7, 3'd3);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(2'd1, pack(8'(8'h40 + 8*k), 8), 2'b00, k == 7));
        end
        send_seq(8'h40, 32);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_byte_ready", 64'(byte_ready), 64'd0);
        chk("bp_rvalid", 64'(rif.RVALID), 64'd1);
        chk("bp_head_a", rif.RDATA, pack(8'h40, 8));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_head_b", rif.RDATA, pack(8'h40, 8));
        rif.RREADY = 1'b1;
        send_seq(8'h60, 32);
        drain();
        chk("bp_overrun", 64'(overrun), 64'd0);

        // overrun while the FIFO is full
        rif.RREADY = 1'b0;
        send_cmd(2'd2, 8'd4, 3'd3);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(2'd2, pack(8'(8'h60 + 8*k), 8), 2'b00, 1'b0));
        end
        exp_q.push_back(mk(2'd2, pack(8'h80, 8), 2'b00, 1'b1));
        send_seq(8'h60, 32);
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_byte_ready", 64'(byte_ready), 64'd0);
        byte_valid = 1'b1;
        byte_data = 8'hEE;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        chk("ovr_set", 64'(overrun), 64'd1);
        @(posedge clk);
        #1;
        chk("ovr_sticky", 64'(overrun), 64'd1);
        rif.RREADY = 1'b1;
        send_seq(8'h80, 8);
        drain();
        chk("ovr_sticky_end", 64'(overrun), 64'd1);

        // bad size then back-to-back narrow command
        send_cmd(2'd3, 8'd1, 3'd5);
        exp_q.push_back(mk(2'd3, pack(8'h10, 8), 2'b10, 1'b0));
        exp_q.push_back(mk(2'd3, pack(8'h18, 8), 2'b10, 1'b1));
        send_seq(8'h10, 16);
        send_cmd(2'd0, 8'd0, 3'd1);
        exp_q.push_back(mk(2'd0, 64'h0000_0000_0000_C1C0, 2'b00, 1'b1));
        send_seq(8'hC0, 2);
        drain();

        // asynchronous reset with two beats buffered
        rif.RREADY = 1'b0;
        send_cmd(2'd1, 8'd3, 3'd3);
        send_seq(8'h20, 16);
        @(posedge clk);
        #1;
        chk("mid_rvalid_pre", 64'(rif.RVALID), 64'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_rvalid_async", 64'(rif.RVALID), 64'd0);
        chk("mid_cmd_ready_async", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_overrun", 64'(overrun), 64'd0);
        chk("mid_rvalid", 64'(rif.RVALID), 64'd0);
        chk("mid_byte_ready", 64'(byte_ready), 64'd0);
        rif.RREADY = 1'b1;
        send_cmd(2'd2, 8'd0, 3'd0);
        exp_q.push_back(mk(2'd2, 64'h5A, 2'b00, 1'b1));
        send_byte(8'h5A);
        drain();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
